// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, default depth and the thermometer helper for the
// pipeline stall/flush controller.
package pipe_ctrl_pkg;

   localparam int STG_PC  = 0;
   localparam int STG_IF  = 1;
   localparam int STG_ID  = 2;
   localparam int STG_EX  = 3;
   localparam int STG_MEM = 4;
   localparam int STG_WB  = 5;

   localparam int NSTAGE_DFLT = 6;
   localparam int THERM_W     = 32;

   // Bits 0..idx set; a negative index yields an all-zero mask.
   function automatic logic [THERM_W-1:0] therm_mask(input int idx);
      logic [THERM_W-1:0] m;
      m = '0;
      for (int i = 0; i < THERM_W; i++) begin
         if (i <= idx) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/stall_timer.sv
// Counted multi-cycle stall: accepts one request when idle, contributes its
// stage for N cycles including the request cycle, cleared by an older flush.
module stall_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE = NSTAGE_DFLT,
   parameter int CNT_W  = 4,
   parameter int SW     = $clog2(NSTAGE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_i,
   input  logic [SW-1:0]    stage_i,
   input  logic [CNT_W-1:0] cycles_i,
   input  logic             flush_vld_i,
   input  logic [SW-1:0]    flush_idx_i,
   output logic             act_o,
   output logic [SW-1:0]    act_stage_o,
   output logic             busy_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    stg_q, stg_d;
   logic             busy;
   logic             accept;
   logic             clr;

   assign busy        = (cnt_q != '0);
   assign accept      = req_i && (cycles_i != '0) && !busy && !rst;
   assign act_stage_o = accept ? stage_i : stg_q;
   assign act_o       = !rst && (accept || busy);
   assign busy_o      = busy && !rst;
   assign clr         = flush_vld_i && act_o && (act_stage_o < flush_idx_i);

   always_comb begin
      cnt_d = cnt_q;
      stg_d = stg_q;
      if (clr) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = cycles_i - CNT_W'(1);
         stg_d = stage_i;
      end else if (busy) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         stg_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         stg_q <= stg_d;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-stage stall/flush generator, zero-cycle latency from requests; merges
// level and counted stalls, resolves redirects, tracks stall stats and watchdog.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE   = NSTAGE_DFLT,
   parameter int CNT_W    = 4,
   parameter int WDOG_MAX = 255,
   parameter int STAT_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NSTAGE-1:0]         stallreq,
   input  logic [NSTAGE-1:0]         flushreq,
   input  logic                      timed_req,
   input  logic [$clog2(NSTAGE)-1:0] timed_stage,
   input  logic [CNT_W-1:0]          timed_cycles,
   output logic [NSTAGE-1:0]         stall,
   output logic [NSTAGE-1:0]         flush,
   output logic                      timed_busy,
   output logic                      wdog_err,
   output logic [STAT_W-1:0]         stall_cycles
);

   localparam int SW   = $clog2(NSTAGE);
   localparam int WD_W = $clog2(WDOG_MAX + 1);

   logic          tmr_act;
   logic [SW-1:0] tmr_stage;
   logic          lvl_vld, src_vld, fl_vld;
   logic [SW-1:0] lvl_idx, src_idx, fl_idx;

   logic [WD_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
   logic [STAT_W-1:0] stat_q, stat_d;

   stall_timer #(
      .NSTAGE (NSTAGE),
      .CNT_W  (CNT_W),
      .SW     (SW)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .req_i       (timed_req),
      .stage_i     (timed_stage),
      .cycles_i    (timed_cycles),
      .flush_vld_i (fl_vld),
      .flush_idx_i (fl_idx),
      .act_o       (tmr_act),
      .act_stage_o (tmr_stage),
      .busy_o      (timed_busy)
   );

   always_comb begin
      lvl_vld = 1'b0;
      lvl_idx = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         if (stallreq[k] && !rst) begin
            lvl_vld = 1'b1;
            lvl_idx = SW'(k);
         end
      end
      src_vld = lvl_vld || tmr_act;
      src_idx = (tmr_act && (!lvl_vld || tmr_stage > lvl_idx)) ? tmr_stage : lvl_idx;
   end

   // A redirect from a frozen stage waits; flushreq[0] has no younger stages.
   always_comb begin
      fl_vld = 1'b0;
      fl_idx = '0;
      for (int k = 1; k < NSTAGE; k++) begin
         if (flushreq[k] && !rst && (!src_vld || SW'(k) > src_idx)) begin
            fl_vld = 1'b1;
            fl_idx = SW'(k);
         end
      end
   end

   // Eligibility puts every stall source below the flush index, so a flush
   // masks all of them.
   always_comb begin
      flush = fl_vld ? NSTAGE'(therm_mask(int'(fl_idx) - 1)) : '0;
      stall = (src_vld && !fl_vld) ? NSTAGE'(therm_mask(int'(src_idx))) : '0;
      stall = stall & ~flush;
   end

   always_comb begin
      wd_d   = '0;
      err_d  = err_q;
      stat_d = stat_q;
      if (stall[0]) begin
         wd_d = (wd_q == WD_W'(WDOG_MAX)) ? wd_q : wd_q + WD_W'(1);
         if (wd_q >= WD_W'(WDOG_MAX - 1)) err_d = 1'b1;
         if (stat_q != '1) stat_d = stat_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q   <= '0;
         err_q  <= 1'b0;
         stat_q <= '0;
      end else begin
         wd_q   <= wd_d;
         err_q  <= err_d;
         stat_q <= stat_d;
      end
   end

   assign wdog_err     = err_q && !rst;
   assign stall_cycles = stat_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboarded bench for pipeline_ctrl: per-cycle expectations are queued as
// stimulus is driven and compared mid-cycle against the DUT outputs.
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] stallreq, flushreq;
   logic       timed_req;
   logic [2:0] timed_stage;
   logic [3:0] timed_cycles;
   logic [5:0] stall, flush;
   logic       timed_busy, wdog_err;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic [5:0] stall;
      logic [5:0] flush;
      logic       busy;
      logic       wdog;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .NSTAGE   (6),
      .CNT_W    (4),
      .WDOG_MAX (4),
      .STAT_W   (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq     (stallreq),
      .flushreq     (flushreq),
      .timed_req    (timed_req),
      .timed_stage  (timed_stage),
      .timed_cycles (timed_cycles),
      .stall        (stall),
      .flush        (flush),
      .timed_busy   (timed_busy),
      .wdog_err     (wdog_err),
      .stall_cycles (stall_cycles)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, queue its expectation, then compare mid-cycle.
   task automatic cyc(input logic r, input logic [5:0] sr, input logic [5:0] fr,
                      input logic tq, input logic [2:0] ts, input logic [3:0] tc,
                      input logic [5:0] es, input logic [5:0] ef,
                      input logic eb, input logic ew, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      rst          = r;
      stallreq     = sr;
      flushreq     = fr;
      timed_req    = tq;
      timed_stage  = ts;
      timed_cycles = tc;
      e.tag   = tag;
      e.stall = es;
      e.flush = ef;
      e.busy  = eb;
      e.wdog  = ew;
      sb_q.push_back(e);
      #3;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({e.tag, "_stall"}, 32'(stall), 32'(e.stall));
         check({e.tag, "_flush"}, 32'(flush), 32'(e.flush));
         check({e.tag, "_busy"},  32'(timed_busy), 32'(e.busy));
         check({e.tag, "_wdog"},  32'(wdog_err), 32'(e.wdog));
      end
   endtask

   initial begin
      rst = 1'b1; stallreq = '0; flushreq = '0;
      timed_req = 1'b0; timed_stage = '0; timed_cycles = '0;

      // Reset: requests ignored, outputs forced low
      cyc(1, 6'b111111, 6'b001000, 1, 3'd3, 4'd5, 6'b000000, 6'b000000, 0, 0, "rst0");
      cyc(1, 6'b001000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "rst1");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "idle0");
      check("stat_after_rst", stall_cycles, 32'd0);

      // Level stalls: thermometer and merge
      cyc(0, 6'b001000, 6'b000000, 0, 3'd0, 4'd0, 6'b001111, 6'b000000, 0, 0, "lvl_ex");
      cyc(0, 6'b000100, 6'b000000, 0, 3'd0, 4'd0, 6'b000111, 6'b000000, 0, 0, "lvl_id");
      cyc(0, 6'b001100, 6'b000000, 0, 3'd0, 4'd0, 6'b001111, 6'b000000, 0, 0, "lvl_both");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "lvl_off");
      check("stat_lvl", stall_cycles, 32'd3);

      // Timed stall stage 2 for 3 cycles; second request while busy dropped
      cyc(0, 6'b000000, 6'b000000, 1, 3'd2, 4'd3, 6'b000111, 6'b000000, 0, 0, "tmr_c1");
      cyc(0, 6'b000000, 6'b000000, 1, 3'd4, 4'd5, 6'b000111, 6'b000000, 1, 0, "tmr_c2");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000111, 6'b000000, 1, 0, "tmr_c3");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "tmr_done");
      cyc(0, 6'b000000, 6'b000000, 1, 3'd3, 4'd0, 6'b000000, 6'b000000, 0, 0, "tmr_zero");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "tmr_zero2");

      // Flush resolution
      cyc(0, 6'b000000, 6'b001000, 0, 3'd0, 4'd0, 6'b000000, 6'b000111, 0, 0, "fl_ex");
      cyc(0, 6'b010000, 6'b001000, 0, 3'd0, 4'd0, 6'b011111, 6'b000000, 0, 0, "fl_defer");
      cyc(0, 6'b000000, 6'b000001, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "fl_pc");

      // Flush clears an older timed stall
      cyc(0, 6'b000000, 6'b000000, 1, 3'd2, 4'd6, 6'b000111, 6'b000000, 0, 0, "tfl_c1");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000111, 6'b000000, 1, 0, "tfl_c2");
      cyc(0, 6'b000000, 6'b001000, 0, 3'd0, 4'd0, 6'b000000, 6'b000111, 1, 0, "tfl_fl");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "tfl_after");
      check("stat_mid", stall_cycles, 32'd9);

      // Timed and level together: higher index wins
      cyc(0, 6'b001000, 6'b000000, 1, 3'd1, 4'd2, 6'b001111, 6'b000000, 0, 0, "mix_c1");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000011, 6'b000000, 1, 0, "mix_c2");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "mix_done");

      // Flush deferred behind a younger timed stall, fires once it ends
      cyc(0, 6'b000000, 6'b000100, 1, 3'd4, 4'd2, 6'b011111, 6'b000000, 0, 0, "tdef_c1");
      cyc(0, 6'b000000, 6'b000100, 0, 3'd0, 4'd0, 6'b011111, 6'b000000, 1, 0, "tdef_c2");
      cyc(0, 6'b000000, 6'b000100, 0, 3'd0, 4'd0, 6'b000000, 6'b000011, 0, 0, "tdef_fl");
      check("stat_pre_rst", stall_cycles, 32'd13);

      // Reset during an active timed stall
      cyc(0, 6'b000000, 6'b000000, 1, 3'd3, 4'd8, 6'b001111, 6'b000000, 0, 0, "trst_c1");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b001111, 6'b000000, 1, 0, "trst_c2");
      cyc(1, 6'b100000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "trst_rst");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "trst_post");
      check("stat_post_rst", stall_cycles, 32'd0);
      cyc(0, 6'b000000, 6'b000000, 1, 3'd2, 4'd2, 6'b000111, 6'b000000, 0, 0, "trst_new1");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000111, 6'b000000, 1, 0, "trst_new2");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "trst_new3");

      // Watchdog trips after 4 consecutive stalled cycles and is sticky
      cyc(1, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "wd_rst");
      for (int i = 0; i < 4; i++) begin
         cyc(0, 6'b100000, 6'b000000, 0, 3'd0, 4'd0, 6'b111111, 6'b000000, 0, 0, "wd_stall");
      end
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 1, "wd_trip");
      check("stat_wd", stall_cycles, 32'd4);
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 1, "wd_sticky");
      cyc(1, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "wd_clr_rst");
      cyc(0, 6'b000000, 6'b000000, 0, 3'd0, 4'd0, 6'b000000, 6'b000000, 0, 0, "wd_cleared");

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
